// File: rtl/prt_lb_arb_if.sv
// Signal bundle between the requesters, the prt_lb_arb arbiter and the local-bus mux.
// Latency: none; this bundle holds only wires.
// Backpressure: none here; the arbiter signals it on REQ_BUSY_OUT.
interface prt_lb_arb_if #(
   parameter int P_REQ = 2,
   parameter int P_ADR = 22,
   parameter int P_DAT = 32
);
   logic [P_REQ*P_ADR-1:0] REQ_ADR_IN;
   logic [P_REQ*P_DAT-1:0] REQ_DAT_IN;
   logic [P_REQ-1:0]       REQ_WR_IN;
   logic [P_REQ-1:0]       REQ_RD_IN;
   logic [P_REQ-1:0]       REQ_BUSY_OUT;
   logic [P_REQ-1:0]       REQ_ACK_OUT;
   logic [P_REQ-1:0]       REQ_VLD_OUT;
   logic [P_REQ-1:0]       REQ_TO_OUT;
   logic [P_DAT-1:0]       REQ_DAT_OUT;
   logic [P_ADR-1:0]       LB_ADR_OUT;
   logic [P_DAT-1:0]       LB_DIN_OUT;
   logic                   LB_WR_OUT;
   logic                   LB_RD_OUT;
   logic [P_DAT-1:0]       LB_DOUT_IN;
   logic                   LB_VLD_IN;

   // The arbiter side of the bundle.
   modport master (
      input  REQ_ADR_IN, REQ_DAT_IN, REQ_WR_IN, REQ_RD_IN, LB_DOUT_IN, LB_VLD_IN,
      output REQ_BUSY_OUT, REQ_ACK_OUT, REQ_VLD_OUT, REQ_TO_OUT, REQ_DAT_OUT,
             LB_ADR_OUT, LB_DIN_OUT, LB_WR_OUT, LB_RD_OUT
   );

   // The requesters and the local-bus mux, seen together.
   modport slave (
      output REQ_ADR_IN, REQ_DAT_IN, REQ_WR_IN, REQ_RD_IN, LB_DOUT_IN, LB_VLD_IN,
      input  REQ_BUSY_OUT, REQ_ACK_OUT, REQ_VLD_OUT, REQ_TO_OUT, REQ_DAT_OUT,
             LB_ADR_OUT, LB_DIN_OUT, LB_WR_OUT, LB_RD_OUT
   );
endinterface

// File: rtl/prt_lb_arb.sv
// Round-robin arbiter that shares one local-bus master port between P_REQ single-strobe requesters.
// Latency: a strobe at cycle N puts the bus pulse and the ACK at N+2. Grants are at least 3 cycles apart.
// Backpressure: each requester has one slot. REQ_BUSY_OUT is high while the slot is held, and strobes seen while busy are dropped.
module prt_lb_arb #(
   parameter int P_REQ      = 2,
   parameter int P_ADR      = 22,
   parameter int P_DAT      = 32,
   parameter int P_VLD_MASK = 2,
   parameter int P_TIMEOUT  = 255
) (
   input  logic            CLK_IN,
   input  logic            RST_IN,
   prt_lb_arb_if.master    bus
);
   localparam int P_CW = $clog2(P_TIMEOUT + 1);
   localparam int P_GW = (P_REQ > 1) ? $clog2(P_REQ) : 1;
   localparam logic [P_CW-1:0]  L_MASK   = P_CW'(P_VLD_MASK);
   localparam logic [P_CW-1:0]  L_TMO    = P_CW'(P_TIMEOUT);
   localparam logic [P_DAT-1:0] L_TO_DAT = P_DAT'(32'hDEAD_DEAD);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, GAP} state_t;

   state_t           state;
   logic [P_REQ-1:0] busy;
   logic [P_REQ-1:0] slot_wr;
   logic [P_ADR-1:0] slot_adr [P_REQ];
   logic [P_DAT-1:0] slot_dat [P_REQ];
   logic [P_GW-1:0]  rr_ptr;
   logic [P_GW-1:0]  gnt;
   logic             gnt_wr;
   logic [P_GW-1:0]  gnt_c;
   logic             gnt_fnd;
   int               srch_idx;
   logic [P_CW-1:0]  to_cnt;
   logic [P_REQ-1:0] ack;
   logic [P_REQ-1:0] vld;
   logic [P_REQ-1:0] tmo;
   logic [P_DAT-1:0] rdat;
   logic [P_ADR-1:0] lb_adr;
   logic [P_DAT-1:0] lb_din;
   logic             lb_wr;
   logic             lb_rd;

   // Find the first pending slot after the round-robin pointer. The downward scan lets the nearest slot win.
   always_comb begin
      gnt_c    = rr_ptr;
      gnt_fnd  = 1'b0;
      srch_idx = 0;
      for (int i = P_REQ; i >= 1; i--) begin
         srch_idx = int'(rr_ptr) + i;
         if (srch_idx >= P_REQ) begin
            srch_idx = srch_idx - P_REQ;
         end
         if (busy[srch_idx]) begin
            gnt_c   = P_GW'(srch_idx);
            gnt_fnd = 1'b1;
         end
      end
   end

   // A slot takes a strobe only when it is free; a write beats a read. The slot is freed as its GAP cycle ends.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         busy    <= '0;
         slot_wr <= '0;
      end else begin
         for (int k = 0; k < P_REQ; k++) begin
            if (state == GAP && int'(gnt) == k) begin
               busy[k] <= 1'b0;
            end else if (!busy[k] && (bus.REQ_WR_IN[k] || bus.REQ_RD_IN[k])) begin
               busy[k]     <= 1'b1;
               slot_wr[k]  <= bus.REQ_WR_IN[k];
               slot_adr[k] <= bus.REQ_ADR_IN[k*P_ADR +: P_ADR];
               slot_dat[k] <= bus.REQ_DAT_IN[k*P_DAT +: P_DAT];
            end
         end
      end
   end

   // Sequencer. All bus and response outputs are registered. The GAP cycle forces the strobes low so the mux sees every rising edge.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         state  <= IDLE;
         rr_ptr <= P_GW'(P_REQ - 1);
         gnt    <= '0;
         gnt_wr <= 1'b0;
         to_cnt <= '0;
         ack    <= '0;
         vld    <= '0;
         tmo    <= '0;
         rdat   <= '0;
         lb_adr <= '0;
         lb_din <= '0;
         lb_wr  <= 1'b0;
         lb_rd  <= 1'b0;
      end else begin
         ack <= '0;
         vld <= '0;
         tmo <= '0;
         case (state)
            IDLE: begin
               if (gnt_fnd) begin
                  gnt    <= gnt_c;
                  rr_ptr <= gnt_c;
                  gnt_wr <= slot_wr[gnt_c];
                  lb_adr <= slot_adr[gnt_c];
                  lb_din <= slot_dat[gnt_c];
                  if (slot_wr[gnt_c]) begin
                     lb_wr      <= 1'b1;
                     ack[gnt_c] <= 1'b1;
                  end else begin
                     lb_rd <= 1'b1;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               lb_wr  <= 1'b0;
               lb_rd  <= 1'b0;
               to_cnt <= '0;
               state  <= gnt_wr ? GAP : WAIT_RD;
            end
            WAIT_RD: begin
               to_cnt <= to_cnt + 1'b1;
               // Ignore valid for the first few cycles: the mux may still be holding a stale valid registered earlier.
               if (to_cnt >= L_MASK && bus.LB_VLD_IN) begin
                  vld[gnt] <= 1'b1;
                  rdat     <= bus.LB_DOUT_IN;
                  state    <= GAP;
               end else if (to_cnt == L_TMO) begin
                  vld[gnt] <= 1'b1;
                  tmo[gnt] <= 1'b1;
                  rdat     <= L_TO_DAT;
                  state    <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.REQ_BUSY_OUT = busy;
   assign bus.REQ_ACK_OUT  = ack;
   assign bus.REQ_VLD_OUT  = vld;
   assign bus.REQ_TO_OUT   = tmo;
   assign bus.REQ_DAT_OUT  = rdat;
   assign bus.LB_ADR_OUT   = lb_adr;
   assign bus.LB_DIN_OUT   = lb_din;
   assign bus.LB_WR_OUT    = lb_wr;
   assign bus.LB_RD_OUT    = lb_rd;
endmodule

// File: doc/prt_lb_arb.md
Name: prt_lb_arb

Overview:
- Round-robin arbiter that shares one local-bus master port between P_REQ requesters, e.g. policy-maker CPU, host bridge and debug UART.
- Sits upstream of the local bus mux and drives its upstream port.
- Each requester issues single-cycle write/read strobes. The arbiter queues one transaction per requester and sequences it onto the shared bus with level-pulse timing the mux's edge detectors accept.
- Read completion is by valid or by timeout.

Parameters:
P_REQ, 2, number of requesters (2..8)
P_ADR, 22, local bus address width
P_DAT, 32, data width
P_VLD_MASK, 2, cycles after issue during which LB_VLD_IN is ignored (covers mux registering of stale vld)
P_TIMEOUT, 255, max WAIT_RD cycles before forced completion (counter width $clog2(P_TIMEOUT+1))

Ports:
CLK_IN  in  1  clock
RST_IN  in  1  synchronous active-high reset
REQ_ADR_IN  in  P_REQ*P_ADR  per-requester address, requester k at [k*P_ADR+:P_ADR]
REQ_DAT_IN  in  P_REQ*P_DAT  per-requester write data
REQ_WR_IN  in  P_REQ  write strobe, one cycle
REQ_RD_IN  in  P_REQ  read strobe, one cycle
REQ_BUSY_OUT  out  P_REQ  transaction pending/in flight for requester k
REQ_ACK_OUT  out  P_REQ  one-cycle write-issued pulse
REQ_VLD_OUT  out  P_REQ  one-cycle read-data-valid pulse
REQ_TO_OUT  out  P_REQ  one-cycle timeout flag, coincident with REQ_VLD_OUT
REQ_DAT_OUT  out  P_DAT  read data, shared; valid only with a REQ_VLD_OUT bit
LB_ADR_OUT  out  P_ADR  shared bus address
LB_DIN_OUT  out  P_DAT  shared bus write data
LB_WR_OUT  out  1  shared bus write level
LB_RD_OUT  out  1  shared bus read level
LB_DOUT_IN  in  P_DAT  shared bus read data
LB_VLD_IN  in  1  shared bus read valid (level)

Behaviour:
- Reset (synchronous, RST_IN=1): all outputs 0, all pending slots cleared, FSM=IDLE, RR pointer=P_REQ-1 (so requester 0 wins first). Reset mid-transaction aborts it silently; no ACK/VLD is issued.
- Capture: on cycle N, a strobe with REQ_BUSY_OUT[k]=0 latches adr, data and type into slot k; BUSY[k]=1 from N+1.
  - Strobe while BUSY[k]=1 is dropped.
  - WR and RD together: write wins, read dropped.
- FSM states: IDLE, ISSUE, WAIT_RD, GAP.
- IDLE: if any slot is pending, grant the first pending index after the RR pointer, wrapping modulo P_REQ. Pointer := grant. Go to ISSUE.
  - LB_ADR_OUT/LB_DIN_OUT are registered from the slot and held stable from ISSUE through GAP.
- ISSUE, exactly one cycle: LB_WR_OUT or LB_RD_OUT=1.
  - Write: REQ_ACK_OUT[g]=1 this cycle, then GAP.
  - Read: clear timeout counter, then WAIT_RD.
- WAIT_RD: counter increments each cycle.
  - Valid completion: first cycle with counter>=P_VLD_MASK and LB_VLD_IN=1. Next cycle REQ_DAT_OUT=LB_DOUT_IN (sampled), REQ_VLD_OUT[g]=1.
  - Timeout completion: counter reaches P_TIMEOUT. Next cycle REQ_DAT_OUT=32'hDEAD_DEAD, REQ_VLD_OUT[g]=1, REQ_TO_OUT[g]=1.
  - Either completion then goes to GAP.
- GAP, one cycle: LB_WR_OUT=LB_RD_OUT=0, guaranteeing a low cycle so the next rising edge is detected. BUSY[g] clears at GAP exit, then IDLE.
- Write latency: strobe at N gives LB_WR_OUT high at N+2, ACK at N+2, BUSY low at N+4. Back-to-back grant spacing is 3 cycles.
- A requester may strobe again the cycle after BUSY falls.
- Non-granted slots stay pending indefinitely; round-robin guarantees each waits at most P_REQ-1 transactions.
- REQ_DAT_OUT holds its last value between completions.

Test Plan:
- Single write: req0 WR, adr=22'h010004, dat=32'h1234_5678 at N → LB_WR_OUT=1 only at N+2 with that adr/dat; ACK[0] at N+2; BUSY[0] high N+1..N+3.
- Read with valid: req1 RD adr=22'h020000; LB_VLD_IN=1 at issue+1 (masked), LB_DOUT_IN=32'hCAFE_0001 at issue+3 → REQ_VLD_OUT[1] at issue+4 with data 32'hCAFE_0001, TO=0.
- Timeout: read, LB_VLD_IN held 0 → REQ_VLD_OUT and REQ_TO_OUT pulse exactly P_TIMEOUT+1 cycles after WAIT_RD entry, data 32'hDEAD_DEAD; next transaction proceeds normally.
- Fairness: P_REQ=3, all three strobe writes same cycle and restrobe on each BUSY fall → grant order 0,1,2,0,1,2; LB_WR_OUT pulses separated by ≥1 low cycle.
- Drop rules: strobe req0 while BUSY[0]=1 → no extra bus cycle. Simultaneous WR+RD → only the write issued.
- Reset mid-read: assert RST_IN in WAIT_RD → next cycle all outputs 0, BUSY=0, no VLD; a later req0 read completes normally.
